proc_load_unit: RTL and testbench

Parametrised multi-cycle load unit for the TinyRV1 processor datapath. It generalises the single-cycle word load into a handshaked unit that computes the effective address, issues word reads to data memory, and returns byte, half or word results with sign or zero extension. It sits between the decode/execute stage (request side) and the data-memory port (memory side). It holds one outstanding load at a time.

---
 rtl/proc_load_unit.sv | 197 +++++++++++++++++++
 tb/tb_proc_load_unit.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/proc_load_unit.sv
// proc_load_unit: handshaked multi-cycle load unit for the TinyRV1 datapath.
// Computes ea = base + sext(imm), issues word-aligned reads and returns
// byte/half/word results with sign or zero extension. One load in flight.
// Optional feature macro: LOAD_UNIT_MISALIGN_EN (split word-crossing accesses
// into two reads; when undefined, crossing accesses return an error response).
module proc_load_unit #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_val,
    output logic                req_rdy,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [OFFSET_W-1:0] req_imm,
    input  logic [1:0]          req_size,
    input  logic                req_sign,
    input  logic [4:0]          req_rd,
    output logic                mem_req_val,
    input  logic                mem_req_rdy,
    output logic [ADDR_W-1:0]   mem_req_addr,
    input  logic                mem_resp_val,
    input  logic [31:0]         mem_resp_data,
    output logic                resp_val,
    input  logic                resp_rdy,
    output logic [31:0]         resp_data,
    output logic [4:0]          resp_rd,
    output logic                resp_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ0  = 3'd1,
        S_WAIT0 = 3'd2,
`ifdef LOAD_UNIT_MISALIGN_EN
        S_REQ1  = 3'd4,
        S_WAIT1 = 3'd5,
`endif
        S_RESP  = 3'd3
    } state_t;

    state_t state, state_d;
    logic   alive;          // low for the first cycle after reset release

    logic [ADDR_W-1:0] ea, ea_q, word_addr;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [4:0]        rd_q;
    logic [31:0]       data_q;
    logic              err_q;
    logic [2:0]        nbytes;
    logic              cross_in;
    logic              accept, load0;
`ifdef LOAD_UNIT_MISALIGN_EN
    logic              cross_q;
    logic [31:0]       word0_q;
    logic              store_w0, load1;
`endif

    // Wrap-around of the effective address is silent (modulo 2^ADDR_W).
    assign ea        = req_addr + ADDR_W'($signed(req_imm));
    assign nbytes    = (req_size == 2'd0) ? 3'd1 : (req_size == 2'd1) ? 3'd2 : 3'd4;
    assign cross_in  = ({1'b0, ea[1:0]} + nbytes) > 3'd4;
    assign word_addr = {ea_q[ADDR_W-1:2], 2'b00};

    // Shift the {hi,lo} word pair down to the addressed byte, then extend.
    function automatic logic [31:0] extract(input logic [31:0] w1, input logic [31:0] w0,
                                            input logic [1:0] off, input logic [1:0] size,
                                            input logic sgn);
        logic [31:0] lo;
        lo = 32'({w1, w0} >> {off, 3'b000});
        case (size)
            2'd0:    extract = {{24{sgn & lo[7]}}, lo[7:0]};
            2'd1:    extract = {{16{sgn & lo[15]}}, lo[15:0]};
            default: extract = lo;
        endcase
    endfunction

    // State register; reset also holds off req_rdy for one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            alive <= 1'b0;
        end else begin
            state <= state_d;
            alive <= 1'b1;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d      = state;
        req_rdy      = 1'b0;
        mem_req_val  = 1'b0;
        mem_req_addr = '0;
        resp_val     = 1'b0;
        accept       = 1'b0;
        load0        = 1'b0;
`ifdef LOAD_UNIT_MISALIGN_EN
        store_w0     = 1'b0;
        load1        = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                req_rdy = alive;
                if (req_val && alive) begin
                    accept = 1'b1;
`ifdef LOAD_UNIT_MISALIGN_EN
                    state_d = S_REQ0;
`else
                    state_d = cross_in ? S_RESP : S_REQ0;
`endif
                end
            end
            S_REQ0: begin
                mem_req_val  = 1'b1;
                mem_req_addr = word_addr;
                if (mem_req_rdy) state_d = S_WAIT0;
            end
            S_WAIT0: begin
                if (mem_resp_val) begin
`ifdef LOAD_UNIT_MISALIGN_EN
                    if (cross_q) begin
                        store_w0 = 1'b1;
                        state_d  = S_REQ1;
                    end else begin
                        load0   = 1'b1;
                        state_d = S_RESP;
                    end
`else
                    load0   = 1'b1;
                    state_d = S_RESP;
`endif
                end
            end
`ifdef LOAD_UNIT_MISALIGN_EN
            S_REQ1: begin
                mem_req_val  = 1'b1;
                mem_req_addr = word_addr + ADDR_W'(4);
                if (mem_req_rdy) state_d = S_WAIT1;
            end
            S_WAIT1: begin
                if (mem_resp_val) begin
                    load1   = 1'b1;
                    state_d = S_RESP;
                end
            end
`endif
            S_RESP: begin
                resp_val = 1'b1;
                if (resp_rdy) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture and result formation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ea_q    <= '0;
            size_q  <= '0;
            sign_q  <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
`ifdef LOAD_UNIT_MISALIGN_EN
            cross_q <= 1'b0;
            word0_q <= '0;
`endif
        end else begin
            if (accept) begin
                ea_q    <= ea;
                size_q  <= req_size;
                sign_q  <= req_sign;
                rd_q    <= req_rd;
                data_q  <= '0;
`ifdef LOAD_UNIT_MISALIGN_EN
                cross_q <= cross_in;
                err_q   <= 1'b0;
`else
                err_q   <= cross_in;
`endif
            end
            if (load0) data_q <= extract(32'h0, mem_resp_data, ea_q[1:0], size_q, sign_q);
`ifdef LOAD_UNIT_MISALIGN_EN
            if (store_w0) word0_q <= mem_resp_data;
            if (load1)    data_q  <= extract(mem_resp_data, word0_q, ea_q[1:0], size_q, sign_q);
`endif
        end
    end

    // Result outputs read as zero outside RESP.
    assign resp_data = resp_val ? data_q : '0;
    assign resp_rd   = resp_val ? rd_q   : '0;
    assign resp_err  = resp_val ? err_q  : 1'b0;

endmodule

// File: tb/tb_proc_load_unit.sv
// tb_proc_load_unit: self-checking bench for proc_load_unit with a 1-cycle
// behavioural memory and a byte-level reference model of loads.
module tb_proc_load_unit;

`ifdef LOAD_UNIT_MISALIGN_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_val = 1'b0, req_rdy;
    logic [31:0] req_addr = '0;
    logic [11:0] req_imm = '0;
    logic [1:0]  req_size = '0;
    logic        req_sign = 1'b0;
    logic [4:0]  req_rd = '0;
    logic        mem_req_val, mem_req_rdy = 1'b1;
    logic [31:0] mem_req_addr;
    logic        mem_resp_val = 1'b0;
    logic [31:0] mem_resp_data = '0;
    logic        resp_val, resp_rdy = 1'b1;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;

    int total = 0, bad = 0;
    int cyc = 0;

    proc_load_unit #(.ADDR_W(32), .OFFSET_W(12)) dut (
        .clk(clk), .rst(rst),
        .req_val(req_val), .req_rdy(req_rdy), .req_addr(req_addr), .req_imm(req_imm),
        .req_size(req_size), .req_sign(req_sign), .req_rd(req_rd),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
        .mem_resp_val(mem_resp_val), .mem_resp_data(mem_resp_data),
        .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_data(resp_data),
        .resp_rd(resp_rd), .resp_err(resp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Memory contents: two fixed words, everything else a fixed address hash.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        if (a == 32'h104) return 32'h01234567;
        return {a[15:0], a[31:16]} ^ 32'h5A5AC3C3;
    endfunction

    // Memory responder and monitors: sample at negedge, drive #1 after posedge.
    logic        hs_q = 1'b0, stale_q = 1'b0, mem_mute = 1'b0, stale_pulse = 1'b0;
    logic [31:0] haddr_q = '0;
    int          mem_hs_cnt = 0, mem_val_cyc = 0, resp_cnt = 0, rdy_in_resp = 0;
    logic [31:0] mem_addrs[$];
    int          acc_cyc[$];

    always @(negedge clk) begin
        hs_q    = mem_req_val && mem_req_rdy && !mem_mute;
        haddr_q = mem_req_addr;
        stale_q = stale_pulse;
        if (mem_req_val && mem_req_rdy) begin
            mem_hs_cnt++;
            mem_addrs.push_back(mem_req_addr);
        end
        if (mem_req_val) mem_val_cyc++;
        if (resp_val && resp_rdy) resp_cnt++;
        if (resp_val && req_rdy) rdy_in_resp++;
        if (req_val && req_rdy) acc_cyc.push_back(cyc);
    end

    always @(posedge clk) begin
        #1;
        if (hs_q) begin
            mem_resp_val  = 1'b1;
            mem_resp_data = mem_word(haddr_q);
        end else if (stale_q) begin
            mem_resp_val  = 1'b1;
            mem_resp_data = 32'hBAD0BAD0;
        end else begin
            mem_resp_val  = 1'b0;
            mem_resp_data = $urandom;
        end
    end

    // Reference: assemble the addressed bytes, then extend arithmetically.
    function automatic void model(input logic [31:0] base, input logic [11:0] imm,
                                  input logic [1:0] size, input logic sgn,
                                  output logic [31:0] d, output logic e, output logic cr);
        logic [31:0] ea, a, w;
        longint unsigned v;
        int nb;
        ea = base + {{20{imm[11]}}, imm};
        nb = (size == 0) ? 1 : (size == 1) ? 2 : 4;
        cr = (int'(ea[1:0]) + nb) > 4;
        d  = '0;
        e  = cr && !MIS;
        if (e) return;
        v = 0;
        for (int i = 0; i < nb; i++) begin
            a = ea + i;
            w = mem_word({a[31:2], 2'b00});
            v = v + (((w >> (8 * a[1:0])) & 32'hFF) << (8 * i));
        end
        if (sgn && nb < 4 && ((v >> (8 * nb - 1)) & 1) == 1) v = v - (64'd1 << (8 * nb));
        d = v[31:0];
    endfunction

    task automatic do_load(input logic [31:0] base, input logic [11:0] imm, input logic [1:0] size,
                           input logic sgn, input logic [4:0] rd, output int lat,
                           output logic [31:0] d, output logic [4:0] r, output logic e);
        int n;
        lat = -1; d = '0; r = '0; e = 1'b0;
        @(posedge clk); #1;
        req_val = 1'b1; req_addr = base; req_imm = imm; req_size = size; req_sign = sgn; req_rd = rd;
        n = 0;
        @(negedge clk);
        while (!req_rdy && n < 50) begin @(negedge clk); n++; end
        if (!req_rdy) begin req_val = 1'b0; return; end
        @(posedge clk); #1 req_val = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (resp_val) begin lat = c; d = resp_data; r = resp_rd; e = resp_err; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++;
        if ({req_rdy, mem_req_val, resp_val, resp_err} !== 4'b0 || mem_req_addr !== 32'h0 ||
            resp_data !== 32'h0 || resp_rd !== 5'h0) begin
            bad++;
            $display("FAIL reset_outputs: rdy=%b mval=%b maddr=%h rval=%b rdata=%h rd=%h err=%b, want all 0",
                     req_rdy, mem_req_val, mem_req_addr, resp_val, resp_data, resp_rd, resp_err);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (req_rdy !== 1'b1) begin bad++; $display("FAIL reset_release_rdy: got %b want 1", req_rdy); end
    endtask

    task automatic test_basic_lw;
        int lat; logic [31:0] d; logic [4:0] r; logic e;
        mem_addrs.delete();
        do_load(32'h100, 12'h000, 2'd2, 1'b0, 5'd5, lat, d, r, e);
        total++; if (lat !== 3) begin bad++; $display("FAIL lw_latency: got %0d want 3", lat); end
        total++; if (d !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data: got %h want deadbeef", d); end
        total++; if (r !== 5'd5 || e !== 1'b0) begin bad++; $display("FAIL lw_rd_err: got rd=%0d err=%b want 5/0", r, e); end
        total++;
        if (mem_addrs.size() != 1 || mem_addrs[0] !== 32'h100) begin
            bad++; $display("FAIL lw_memreq: got n=%0d addr0=%h want 1 @100", mem_addrs.size(),
                            mem_addrs.size() > 0 ? mem_addrs[0] : 32'hFFFFFFFF);
        end
    endtask

    task automatic test_neg_offset;
        int lat; logic [31:0] d; logic [4:0] r; logic e;
        mem_addrs.delete();
        do_load(32'h108, 12'hFFC, 2'd2, 1'b0, 5'd9, lat, d, r, e);
        total++; if (d !== 32'h01234567) begin bad++; $display("FAIL negoff_data: got %h want 01234567", d); end
        total++;
        if (mem_addrs.size() != 1 || mem_addrs[0] !== 32'h104) begin
            bad++; $display("FAIL negoff_addr: got n=%0d addr0=%h want 104", mem_addrs.size(),
                            mem_addrs.size() > 0 ? mem_addrs[0] : 32'hFFFFFFFF);
        end
    endtask

    task automatic test_subword;
        logic [31:0] eas [5] = '{32'h101, 32'h101, 32'h102, 32'h102, 32'h101};
        logic [1:0]  szs [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1};
        logic        sgs [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exp [5] = '{32'hFFFFFFBE, 32'h000000BE, 32'hFFFFDEAD, 32'h0000DEAD, 32'hFFFFADBE};
        int lat; logic [31:0] d; logic [4:0] r; logic e;
        for (int i = 0; i < 5; i++) begin
            do_load(eas[i], 12'h000, szs[i], sgs[i], 5'(i + 1), lat, d, r, e);
            total++;
            if (d !== exp[i] || lat !== 3 || e !== 1'b0) begin
                bad++; $display("FAIL subword_%0d: got d=%h lat=%0d err=%b want %h/3/0", i, d, lat, e, exp[i]);
            end
        end
    endtask

    task automatic test_crossing;
        int lat, v0; logic [31:0] d; logic [4:0] r; logic e;
        mem_addrs.delete();
        v0 = mem_val_cyc;
        do_load(32'h102, 12'h000, 2'd2, 1'b0, 5'd7, lat, d, r, e);
        if (MIS) begin
            total++;
            if (d !== 32'h4567DEAD || e !== 1'b0 || lat !== 5) begin
                bad++; $display("FAIL cross_result: got d=%h err=%b lat=%0d want 4567dead/0/5", d, e, lat);
            end
            total++;
            if (mem_addrs.size() != 2 || mem_addrs[0] !== 32'h100 || mem_addrs[1] !== 32'h104) begin
                bad++; $display("FAIL cross_addrs: got n=%0d want reads of 100 then 104", mem_addrs.size());
            end
        end else begin
            total++;
            if (d !== 32'h0 || e !== 1'b1 || lat !== 1 || r !== 5'd7) begin
                bad++; $display("FAIL cross_err: got d=%h err=%b lat=%0d rd=%0d want 0/1/1/7", d, e, lat, r);
            end
            total++;
            if (mem_val_cyc != v0) begin bad++; $display("FAIL cross_nomem: got %0d mem_req_val cycles want 0", mem_val_cyc - v0); end
        end
    endtask

    task automatic test_random;
        int lat, h0, elat, ehs; logic [31:0] d, ed, base; logic [4:0] r, rd; logic e, ee, cr;
        logic [11:0] imm; logic [1:0] sz; logic sg;
        for (int i = 0; i < 40; i++) begin
            base = (i < 20) ? 32'h100 + $urandom_range(0, 15) : $urandom;
            imm  = (i < 20) ? 12'h0 : 12'($urandom);
            sz = 2'($urandom_range(0, 3)); sg = 1'($urandom); rd = 5'($urandom);
            model(base, imm, sz, sg, ed, ee, cr);
            elat = ee ? 1 : cr ? 5 : 3;
            ehs  = ee ? 0 : cr ? 2 : 1;
            h0 = mem_hs_cnt;
            do_load(base, imm, sz, sg, rd, lat, d, r, e);
            total++;
            if (d !== ed || e !== ee || r !== rd || lat !== elat || (mem_hs_cnt - h0) != ehs) begin
                bad++;
                $display("FAIL random_%0d: base=%h imm=%h sz=%0d sg=%b got d=%h err=%b rd=%0d lat=%0d reads=%0d want %h/%b/%0d/%0d/%0d",
                         i, base, imm, sz, sg, d, e, r, lat, mem_hs_cnt - h0, ed, ee, rd, elat, ehs);
            end
        end
    endtask

    task automatic test_backpressure;
        int n, r0; logic seen;
        r0 = resp_cnt;
        @(posedge clk); #1;
        mem_req_rdy = 1'b0; resp_rdy = 1'b0;
        req_val = 1'b1; req_addr = 32'h100; req_imm = 12'h0; req_size = 2'd2; req_sign = 1'b0; req_rd = 5'd3;
        @(posedge clk); #1 req_val = 1'b0;   // IDLE with rdy: accept on this edge
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (mem_req_val !== 1'b1 || mem_req_addr !== 32'h100 || req_rdy !== 1'b0) begin
                bad++; $display("FAIL bp_memstall_%0d: got mval=%b addr=%h rdy=%b want 1/100/0", c, mem_req_val, mem_req_addr, req_rdy);
            end
        end
        @(posedge clk); #1 mem_req_rdy = 1'b1;
        seen = 1'b0; n = 0;
        while (!seen && n < 20) begin @(negedge clk); seen = resp_val; n++; end
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            total++;
            if (resp_val !== 1'b1 || resp_data !== 32'hDEADBEEF || resp_rd !== 5'd3 || resp_err !== 1'b0 || req_rdy !== 1'b0) begin
                bad++; $display("FAIL bp_respstall_%0d: got val=%b d=%h rd=%0d err=%b rdy=%b want 1/deadbeef/3/0/0",
                                c, resp_val, resp_data, resp_rd, resp_err, req_rdy);
            end
        end
        @(posedge clk); #1 resp_rdy = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (resp_cnt - r0 != 1) begin bad++; $display("FAIL bp_count: got %0d responses want 1", resp_cnt - r0); end
    endtask

    task automatic test_back_to_back;
        int n, r0;
        r0 = resp_cnt;
        rdy_in_resp = 0;
        acc_cyc.delete();
        @(posedge clk); #1;
        req_val = 1'b1; req_addr = 32'h104; req_imm = 12'h0; req_size = 2'd2; req_sign = 1'b0; req_rd = 5'd1;
        n = 0;
        while (acc_cyc.size() < 2 && n < 40) begin @(posedge clk); #1; n++; end
        req_val = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        total++;
        if (acc_cyc.size() != 2 || acc_cyc[1] - acc_cyc[0] != 4) begin
            bad++; $display("FAIL b2b_spacing: got n=%0d gap=%0d want 2 accepts 4 cycles apart", acc_cyc.size(),
                            acc_cyc.size() >= 2 ? acc_cyc[1] - acc_cyc[0] : -1);
        end
        total++;
        if (resp_cnt - r0 != 2 || rdy_in_resp != 0) begin
            bad++; $display("FAIL b2b_resp: got resps=%0d rdy_during_resp=%0d want 2/0", resp_cnt - r0, rdy_in_resp);
        end
    endtask

    task automatic test_reset_midop;
        int lat, r0; logic [31:0] d; logic [4:0] r; logic e;
        @(posedge clk); #1;
        mem_mute = 1'b1;
        req_val = 1'b1; req_addr = 32'h100; req_imm = 12'h0; req_size = 2'd2; req_sign = 1'b0; req_rd = 5'd4;
        @(posedge clk); #1 req_val = 1'b0;   // accepted; REQ0 now
        @(posedge clk);                      // request handshake; WAIT0 now
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if ({req_rdy, mem_req_val, resp_val, resp_err} !== 4'b0 || mem_req_addr !== 32'h0 ||
            resp_data !== 32'h0 || resp_rd !== 5'h0) begin
            bad++; $display("FAIL midop_reset_outputs: rdy=%b mval=%b maddr=%h rval=%b want all 0", req_rdy, mem_req_val, mem_req_addr, resp_val);
        end
        @(posedge clk); #1;
        rst = 1'b1; mem_mute = 1'b0; stale_pulse = 1'b1;
        @(posedge clk); #1 stale_pulse = 1'b0;
        r0 = resp_cnt;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (resp_val !== 1'b0 || mem_req_val !== 1'b0) begin
                bad++; $display("FAIL midop_stale: got rval=%b mval=%b want 0/0", resp_val, mem_req_val);
            end
        end
        do_load(32'h104, 12'h0, 2'd2, 1'b0, 5'd6, lat, d, r, e);
        total++;
        if (d !== 32'h01234567 || lat !== 3 || r !== 5'd6 || e !== 1'b0 || resp_cnt - r0 != 1) begin
            bad++; $display("FAIL midop_next_lw: got d=%h lat=%0d rd=%0d err=%b n=%0d want 01234567/3/6/0/1", d, lat, r, e, resp_cnt - r0);
        end
    endtask

    initial begin
        test_reset();
        test_basic_lw();
        test_neg_offset();
        test_subword();
        test_crossing();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
